// File: rtl/gpio_in_if.sv
// Bus-side view of the GPIO input conditioner: configuration, clear pulses and conditioned outputs.
// The register block holds the master side and the conditioner holds the slave side.
interface gpio_in_if #(
    parameter int PINS          = 32,
    parameter int DEBOUNCE_BITS = 8
);
    logic [DEBOUNCE_BITS-1:0] db_limit;
    logic [PINS-1:0]          rise_en;
    logic [PINS-1:0]          fall_en;
    logic [PINS-1:0]          irq_clear;
    logic [PINS-1:0]          in_clean;
    logic [PINS-1:0]          irq_pending;
    logic                     irq;

    modport master (
        output db_limit, rise_en, fall_en, irq_clear,
        input  in_clean, irq_pending, irq
    );

    modport slave (
        input  db_limit, rise_en, fall_en, irq_clear,
        output in_clean, irq_pending, irq
    );
endinterface

// File: rtl/gpio_input_conditioner.sv
// Pin-side front end: synchroniser chain, optional debounce (GPIO_IN_DEBOUNCE_EN), and sticky
// per-pin edge flags with a registered-source level interrupt.
module gpio_input_conditioner #(
    parameter int PINS          = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int DEBOUNCE_BITS = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [PINS-1:0] pins_in,
    gpio_in_if.slave        bus
);

    logic [PINS-1:0] sync_q [SYNC_STAGES];
    logic [PINS-1:0] sync;
    logic [PINS-1:0] in_clean_q;
    logic [PINS-1:0] in_prev_q;
    logic [PINS-1:0] pending_q;
    logic [PINS-1:0] rise;
    logic [PINS-1:0] fall;

    // Plain flop chain; nothing may sit between stages or metastability can leak through.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
            sync_q[0] <= pins_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_IN_DEBOUNCE_EN
    logic [DEBOUNCE_BITS-1:0] cnt_q [PINS];

    // ">=" lets a db_limit lowered mid-count release the pin on the very next edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the counter array is reset too, so a reset mid-debounce discards any partial count.
            for (int i = 0; i < PINS; i++) cnt_q[i] <= '0;
            in_clean_q <= '0;
        end else begin
            for (int i = 0; i < PINS; i++) begin
                if (sync[i] == in_clean_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] >= bus.db_limit) begin
                    in_clean_q[i] <= sync[i];
                    cnt_q[i]      <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end
`else
    logic [DEBOUNCE_BITS-1:0] unused_db_limit;
    assign unused_db_limit = bus.db_limit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) in_clean_q <= '0;
        else       in_clean_q <= sync;
    end
`endif

    assign rise = in_clean_q & ~in_prev_q;
    assign fall = ~in_clean_q & in_prev_q;

    // A new edge in the same cycle as a clear pulse keeps the flag set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_prev_q <= '0;
            pending_q <= '0;
        end else begin
            in_prev_q <= in_clean_q;
            pending_q <= (pending_q & ~bus.irq_clear)
                       | (rise & bus.rise_en)
                       | (fall & bus.fall_en);
        end
    end

    assign bus.in_clean    = in_clean_q;
    assign bus.irq_pending = pending_q;
    assign bus.irq         = |pending_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Self-checking bench for gpio_input_conditioner: a history-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations (both debounce build options).
module tb_gpio_input_conditioner;

    localparam int PINS          = 32;
    localparam int SYNC_STAGES   = 2;
    localparam int DEBOUNCE_BITS = 8;
`ifdef GPIO_IN_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic [PINS-1:0] pins_in;
    int              total = 0;
    int              bad   = 0;

    gpio_in_if #(.PINS(PINS), .DEBOUNCE_BITS(DEBOUNCE_BITS)) bus ();

    gpio_input_conditioner #(
        .PINS(PINS), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .pins_in (pins_in),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pin samples delayed by the synchroniser depth, and a per-pin run length of
    // synchronised samples that disagree with the clean level decides when the clean level flips.
    logic [PINS-1:0] pq[$];
    logic [PINS-1:0] hq[$];
    logic [PINS-1:0] m_clean, m_prev, m_pend;

    always @(posedge clock or posedge reset) begin
        logic [PINS-1:0] s, nclean, m_rise, m_fall;
        int run;
        if (reset) begin
            pq.delete();
            hq.delete();
            m_clean = '0;
            m_prev  = '0;
            m_pend  = '0;
        end else begin
            s = (pq.size() >= SYNC_STAGES) ? pq[SYNC_STAGES-1] : '0;
            pq.push_front(pins_in);
            if (pq.size() > SYNC_STAGES) void'(pq.pop_back());
            hq.push_front(s);
            if (hq.size() > 300) void'(hq.pop_back());
            nclean = m_clean;
            for (int i = 0; i < PINS; i++) begin
                if (DB_EN) begin
                    run = 0;
                    while (run < hq.size() && hq[run][i] != m_clean[i]) run++;
                    if (run >= int'(bus.db_limit) + 1) nclean[i] = s[i];
                end else begin
                    nclean[i] = s[i];
                end
            end
            m_rise = m_clean & ~m_prev;
            m_fall = ~m_clean & m_prev;
            m_pend = (m_pend & ~bus.irq_clear) | (m_rise & bus.rise_en) | (m_fall & bus.fall_en);
            m_prev  = m_clean;
            m_clean = nclean;
        end
    end

    always @(negedge clock) begin
        check("cmp_in_clean", bus.in_clean, m_clean);
        check("cmp_irq_pending", bus.irq_pending, m_pend);
        check("cmp_irq", {31'b0, bus.irq}, {31'b0, |m_pend});
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        int lat;
        reset         = 1'b0;
        pins_in       = '0;
        bus.db_limit  = '0;
        bus.rise_en   = '0;
        bus.fall_en   = '0;
        bus.irq_clear = '0;
        #2 reset = 1'b1;
        #1;
        check("rst_in_clean", bus.in_clean, 32'h0);
        check("rst_pending", bus.irq_pending, 32'h0);
        check("rst_irq", {31'b0, bus.irq}, 32'h0);
        cyc(2);
        reset = 1'b0;
        cyc(2);

        // Single pin rising edge, no debounce.
        bus.rise_en = 32'h8;
        pins_in[3]  = 1'b1;
        cyc(2);
        check("t1_clean_early", bus.in_clean, 32'h0);
        cyc(1);
        check("t1_clean", bus.in_clean, 32'h8);
        check("t1_pend_early", bus.irq_pending, 32'h0);
        cyc(1);
        check("t1_pend", bus.irq_pending, 32'h8);
        check("t1_irq", {31'b0, bus.irq}, 32'h1);
        bus.irq_clear = 32'h8;
        cyc(1);
        bus.irq_clear = '0;
        check("t1_cleared", bus.irq_pending, 32'h0);
        pins_in[3] = 1'b0;
        cyc(6);
        check("t1_fall_ignored", bus.irq_pending, 32'h0);

        // Glitch shorter than the debounce window, then a held level.
        bus.db_limit = 8'd4;
        bus.rise_en  = 32'h1;
        pins_in[0]   = 1'b1;
        cyc(3);
        pins_in[0] = 1'b0;
        cyc(12);
        check("t2_glitch_clean", bus.in_clean, 32'h0);
        check("t2_glitch_pend", bus.irq_pending, DB_EN ? 32'h0 : 32'h1);
        bus.irq_clear = '1;
        cyc(1);
        bus.irq_clear = '0;
        pins_in[0] = 1'b1;
        cyc(6);
        check("t2_hold_early", bus.in_clean, DB_EN ? 32'h0 : 32'h1);
        cyc(1);
        check("t2_hold_clean", bus.in_clean, 32'h1);
        pins_in[0] = 1'b0;
        cyc(12);
        bus.irq_clear = '1;
        cyc(1);
        bus.irq_clear = '0;

        // Falling-edge only, clear pulse, and clear colliding with a new fall.
        bus.db_limit = 8'd0;
        bus.rise_en  = '0;
        bus.fall_en  = 32'h80;
        pins_in[7]   = 1'b1;
        cyc(6);
        check("t3_rise_ignored", bus.irq_pending, 32'h0);
        pins_in[7] = 1'b0;
        cyc(3);
        check("t3_pend_early", bus.irq_pending, 32'h0);
        cyc(1);
        check("t3_fall_pend", bus.irq_pending, 32'h80);
        check("t3_irq", {31'b0, bus.irq}, 32'h1);
        pins_in[7] = 1'b1;
        cyc(6);
        check("t3_pend_kept", bus.irq_pending, 32'h80);
        bus.irq_clear = 32'h80;
        cyc(1);
        bus.irq_clear = '0;
        check("t3_cleared", bus.irq_pending, 32'h0);
        check("t3_irq_low", {31'b0, bus.irq}, 32'h0);
        pins_in[7] = 1'b0;
        cyc(3);
        bus.irq_clear = 32'h80;
        cyc(1);
        bus.irq_clear = '0;
        check("t3_set_wins", bus.irq_pending, 32'h80);
        bus.fall_en = '0;
        cyc(2);
        check("t3_disable_keeps", bus.irq_pending, 32'h80);

        // Asynchronous reset in the middle of a debounce count.
        pins_in[9] = 1'b1;
        cyc(4);
        check("t4_pre_clean", bus.in_clean, 32'h200);
        check("t4_pre_pend", bus.irq_pending, 32'h80);
        bus.db_limit = 8'd10;
        bus.rise_en  = 32'h20;
        pins_in[5]   = 1'b1;
        cyc(7);
        #2 reset = 1'b1;
        #1;
        check("t4_rst_clean", bus.in_clean, 32'h0);
        check("t4_rst_pend", bus.irq_pending, 32'h0);
        check("t4_rst_irq", {31'b0, bus.irq}, 32'h0);
        cyc(2);
        reset = 1'b0;
        lat = DB_EN ? SYNC_STAGES + 1 + 10 : SYNC_STAGES + 1;
        cyc(lat - 1);
        check("t4_clean_early", bus.in_clean, 32'h0);
        cyc(1);
        check("t4_clean", bus.in_clean, 32'h220);
        check("t4_pend_early", bus.irq_pending, 32'h0);
        cyc(1);
        check("t4_rise_pend", bus.irq_pending, 32'h20);

        // All pins at once, then split clears.
        bus.db_limit = 8'd0;
        pins_in = '0;
        cyc(5);
        bus.irq_clear = '1;
        cyc(1);
        bus.irq_clear = '0;
        check("t5_start", bus.irq_pending, 32'h0);
        bus.rise_en = '1;
        pins_in = '1;
        cyc(4);
        check("t5_all_pend", bus.irq_pending, 32'hFFFF_FFFF);
        bus.irq_clear = 32'h0000_FFFF;
        cyc(1);
        bus.irq_clear = '0;
        check("t5_half_pend", bus.irq_pending, 32'hFFFF_0000);
        check("t5_half_irq", {31'b0, bus.irq}, 32'h1);
        bus.irq_clear = 32'hFFFF_0000;
        cyc(1);
        bus.irq_clear = '0;
        check("t5_none_pend", bus.irq_pending, 32'h0);
        check("t5_irq_low", {31'b0, bus.irq}, 32'h0);

        // Lowering db_limit mid-count releases the pin on the next edge.
        bus.db_limit = 8'd20;
        bus.fall_en  = 32'h2;
        pins_in[1]   = 1'b0;
        cyc(10);
        check("t6_before", bus.in_clean, DB_EN ? 32'hFFFF_FFFF : 32'hFFFF_FFFD);
        bus.db_limit = 8'd3;
        cyc(1);
        check("t6_after", bus.in_clean, 32'hFFFF_FFFD);
        cyc(1);
        check("t6_pend", bus.irq_pending, 32'h2);

        cyc(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
